fwd_hazard_ctrl: RTL and testbench

- Forwarding and hazard controller for the 5-stage pipeline.
- Tracks the destination register of the instructions in EX and MEM using internal shadow registers.
- Drives the 2-bit selects of the two EX-stage 3:1 operand muxes (A and B).
- Raises a load-use stall and inserts a bubble into EX. Also counts stall cycles for performance debug.

---
 rtl/pipe_ctrl_pkg.sv | 16 +
 rtl/fwd_match.sv | 44 ++++
 rtl/fwd_hazard_ctrl.sv | 124 ++++++++++++
 tb/tb_fwd_hazard_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: constants shared by the forwarding/hazard controller and
// the EX-stage operand mux instantiation.
//   FWD_RF/FWD_MEMWB/FWD_EXMEM : 2-bit operand mux select encoding
//   REG_ZERO                   : hard-wired zero register, never a producer
package pipe_ctrl_pkg;

   localparam logic [1:0] FWD_RF    = 2'b00;  // register-file value
   localparam logic [1:0] FWD_MEMWB = 2'b01;  // MEM/WB result
   localparam logic [1:0] FWD_EXMEM = 2'b10;  // EX/MEM result

   localparam int REG_ZERO = 0;

   // Operand index into the per-source match array.
   typedef enum int {OPND_A = 0, OPND_B = 1} opnd_e;

endpackage

// File: rtl/fwd_match.sv
// fwd_match: combinational compare of one ID source register against the
// EX and MEM writers.
//   src, src_en        : source specifier and "this source is really read"
//   ex_wr/ex_dst       : EX stage holds a writer of ex_dst
//   ex_memread         : the EX writer is a load
//   mem_wr/mem_dst     : MEM stage holds a writer of mem_dst
//   sel                : operand mux select (newest producer wins)
//   hit                : source depends on EX or MEM
//   load_hit           : source depends on a load still in EX
module fwd_match
   import pipe_ctrl_pkg::*;
#(
   parameter int REG_W  = 5,
   parameter int FWD_EN = 1
) (
   input  logic [REG_W-1:0] src,
   input  logic             src_en,
   input  logic             ex_wr,
   input  logic [REG_W-1:0] ex_dst,
   input  logic             ex_memread,
   input  logic             mem_wr,
   input  logic [REG_W-1:0] mem_dst,
   output logic [1:0]       sel,
   output logic             hit,
   output logic             load_hit
);

   logic ex_hit;
   logic mem_hit;

   assign ex_hit   = src_en & ex_wr  & (src == ex_dst);
   assign mem_hit  = src_en & mem_wr & (src == mem_dst);
   assign hit      = ex_hit | mem_hit;
   assign load_hit = ex_hit & ex_memread;

   always_comb begin
      sel = FWD_RF;
      if (FWD_EN != 0) begin
         if (ex_hit)       sel = FWD_EXMEM;
         else if (mem_hit) sel = FWD_MEMWB;
      end
   end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl: forwarding and load-use hazard controller for the 5-stage
// pipeline. Shadows the destination info of the EX and MEM instructions,
// registers the EX operand mux selects and raises a combinational stall.
//   clk, reset          : clock, synchronous active-high reset
//   hold                : global freeze, no state changes
//   flush               : kill the ID instruction (branch taken)
//   id_*                : decoded fields of the instruction in ID
//   fwd_a_sel/fwd_b_sel : registered EX operand mux selects
//   stall               : freeze PC/IF-ID, bubble into ID/EX
//   stall_count         : wrapping count of non-hold cycles with stall=1
module fwd_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int REG_W  = 5,
   parameter int FWD_EN = 1,
   parameter int CNT_W  = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             hold,
   input  logic             flush,
   input  logic             id_valid,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_uses_rt,
   input  logic [REG_W-1:0] id_dst,
   input  logic             id_regwrite,
   input  logic             id_memread,
   output logic [1:0]       fwd_a_sel,
   output logic [1:0]       fwd_b_sel,
   output logic             stall,
   output logic [CNT_W-1:0] stall_count
);

   localparam int NSRC = 2;

   // vld_pipe[0] = EX valid, vld_pipe[1] = MEM valid
   logic [1:0]       vld_pipe;
   logic [REG_W-1:0] ex_dst, mem_dst;
   logic             ex_regwrite, mem_regwrite;
   logic             ex_memread;

   logic ex_wr, mem_wr;
   logic adv;

   logic [NSRC-1:0][REG_W-1:0] src;
   logic [NSRC-1:0]            src_en;
   logic [NSRC-1:0][1:0]       sel;
   logic [NSRC-1:0]            hit;
   logic [NSRC-1:0]            load_hit;

   // $0 is never a producer, so it can neither forward nor stall.
   assign ex_wr  = vld_pipe[0] & ex_regwrite  & (ex_dst  != REG_W'(REG_ZERO));
   assign mem_wr = vld_pipe[1] & mem_regwrite & (mem_dst != REG_W'(REG_ZERO));

   assign src[OPND_A]    = id_rs;
   assign src[OPND_B]    = id_rt;
   assign src_en[OPND_A] = 1'b1;
   assign src_en[OPND_B] = id_uses_rt;

   for (genvar g = 0; g < NSRC; g++) begin : g_src
      fwd_match #(
         .REG_W  (REG_W),
         .FWD_EN (FWD_EN)
      ) u_match (
         .src        (src[g]),
         .src_en     (src_en[g]),
         .ex_wr      (ex_wr),
         .ex_dst     (ex_dst),
         .ex_memread (ex_memread),
         .mem_wr     (mem_wr),
         .mem_dst    (mem_dst),
         .sel        (sel[g]),
         .hit        (hit[g]),
         .load_hit   (load_hit[g])
      );
   end

   // With forwarding only a load still in EX cannot be bypassed; without it
   // any pending producer in EX or MEM blocks the ID instruction.
   always_comb begin
      stall = 1'b0;
      if (id_valid && !flush) begin
         if (FWD_EN != 0) stall = |load_hit;
         else             stall = |hit;
      end
   end

   assign adv = ~(flush | stall);

   always_ff @(posedge clk) begin
      if (reset) begin
         vld_pipe     <= '0;
         ex_dst       <= '0;
         ex_regwrite  <= 1'b0;
         ex_memread   <= 1'b0;
         mem_dst      <= '0;
         mem_regwrite <= 1'b0;
         fwd_a_sel    <= FWD_RF;
         fwd_b_sel    <= FWD_RF;
         stall_count  <= '0;
      end else if (!hold) begin
         // MEM always inherits EX; EX takes ID only when ID advances.
         vld_pipe     <= {vld_pipe[0], adv & id_valid};
         mem_dst      <= ex_dst;
         mem_regwrite <= ex_regwrite;
         if (adv) begin
            ex_dst      <= id_dst;
            ex_regwrite <= id_regwrite;
            ex_memread  <= id_memread;
         end
         // A bubble carries no operands, so it gets register-file selects.
         if (adv && id_valid) begin
            fwd_a_sel <= sel[OPND_A];
            fwd_b_sel <= sel[OPND_B];
         end else begin
            fwd_a_sel <= FWD_RF;
            fwd_b_sel <= FWD_RF;
         end
         if (stall) stall_count <= stall_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Scoreboard bench: stimulus pushes expected outputs tagged with the cycle
// they belong to; a negedge monitor pops and compares them.
// dut1: FWD_EN=1, CNT_W=32. dut0: FWD_EN=0, CNT_W=2 (exercises counter wrap).
module tb_fwd_hazard_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       hold = 1'b0;
   logic       flush = 1'b0;
   logic       id_valid = 1'b0;
   logic [4:0] id_rs = '0, id_rt = '0, id_dst = '0;
   logic       id_uses_rt = 1'b0, id_regwrite = 1'b0, id_memread = 1'b0;

   logic [1:0]  a1, b1, a0, b0;
   logic        st1, st0;
   logic [31:0] cnt1;
   logic [1:0]  cnt0;

   always #5 clk = ~clk;

   fwd_hazard_ctrl #(.REG_W(5), .FWD_EN(1), .CNT_W(32)) dut1 (
      .clk(clk), .reset(reset), .hold(hold), .flush(flush),
      .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rt(id_uses_rt), .id_dst(id_dst), .id_regwrite(id_regwrite),
      .id_memread(id_memread), .fwd_a_sel(a1), .fwd_b_sel(b1),
      .stall(st1), .stall_count(cnt1));

   fwd_hazard_ctrl #(.REG_W(5), .FWD_EN(0), .CNT_W(2)) dut0 (
      .clk(clk), .reset(reset), .hold(hold), .flush(flush),
      .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rt(id_uses_rt), .id_dst(id_dst), .id_regwrite(id_regwrite),
      .id_memread(id_memread), .fwd_a_sel(a0), .fwd_b_sel(b0),
      .stall(st0), .stall_count(cnt0));

   typedef struct packed {
      logic       v;
      logic [4:0] rs, rt;
      logic       ut;
      logic [4:0] dst;
      logic       rw, mr;
   } id_t;

   typedef struct {
      int       cyc;
      bit       d;
      bit [1:0] a, b;
      bit       st;
      int       cnt;
      string    name;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic id_t nop();
      return '0;
   endfunction

   function automatic id_t alu(int dst, int rs, int rt);
      id_t i = '0;
      i.v = 1; i.rs = rs[4:0]; i.rt = rt[4:0]; i.ut = 1;
      i.dst = dst[4:0]; i.rw = 1;
      return i;
   endfunction

   function automatic id_t lw(int dst, int rs);
      id_t i = '0;
      i.v = 1; i.rs = rs[4:0]; i.dst = dst[4:0]; i.rw = 1; i.mr = 1;
      return i;
   endfunction

   // One cycle of stimulus; when chk=1 the expected outputs of dut d for
   // this cycle are queued.
   task automatic step(input id_t i, input bit fl, input bit hd, input bit rst,
                       input bit chk, input bit d, input bit [1:0] ea,
                       input bit [1:0] eb, input bit es, input int ec,
                       input string nm);
      exp_t e;
      @(posedge clk);
      #1;
      id_valid = i.v; id_rs = i.rs; id_rt = i.rt; id_uses_rt = i.ut;
      id_dst = i.dst; id_regwrite = i.rw; id_memread = i.mr;
      flush = fl; hold = hd; reset = rst;
      if (chk) begin
         e.cyc = cyc; e.d = d; e.a = ea; e.b = eb; e.st = es; e.cnt = ec;
         e.name = nm;
         sb.push_back(e);
      end
   endtask

   task automatic rst();
      step(nop(), 0, 0, 1, 0, 1, 2'b00, 2'b00, 0, 0, "");
   endtask

   task automatic go(input id_t i, input bit d, input bit [1:0] ea,
                     input bit [1:0] eb, input bit es, input int ec,
                     input string nm);
      step(i, 0, 0, 0, 1, d, ea, eb, es, ec, nm);
   endtask

   task automatic pre(input id_t i);
      step(i, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 0, "");
   endtask

   // Monitor: compare whatever expectations belong to the current cycle.
   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].cyc == cyc) begin
         exp_t e;
         logic [1:0] ra, rb;
         logic       rs;
         int         rc;
         e  = sb.pop_front();
         ra = e.d ? a1 : a0;
         rb = e.d ? b1 : b0;
         rs = e.d ? st1 : st0;
         rc = e.d ? int'(cnt1) : int'(cnt0);
         checks++;
         if (ra !== e.a || rb !== e.b || rs !== e.st || rc != e.cnt) begin
            errors++;
            $display("FAIL %s (dut%0d cyc %0d): got a=%b b=%b stall=%b cnt=%0d, want a=%b b=%b stall=%b cnt=%0d",
                     e.name, e.d, cyc, ra, rb, rs, rc, e.a, e.b, e.st, e.cnt);
         end
      end
   end

   initial begin
      // reset state, both configurations
      rst();
      step(nop(), 0, 0, 1, 1, 1, 2'b00, 2'b00, 0, 0, "reset_fwd");
      sb.push_back('{cyc, 1'b0, 2'b00, 2'b00, 1'b0, 0, "reset_nofwd"});

      // EX/MEM forward: add $3,$1,$2 ; sub $4,$3,$5
      rst();
      go(alu(3, 1, 2), 1, 2'b00, 2'b00, 0, 0, "t1_add_id");
      go(alu(4, 3, 5), 1, 2'b00, 2'b00, 0, 0, "t1_sub_id_nostall");
      go(nop(),        1, 2'b10, 2'b00, 0, 0, "t1_sub_ex_sel");

      // MEM/WB forward: add $3 ; nop ; or $6,$7,$3
      rst();
      pre(alu(3, 1, 2));
      pre(nop());
      go(alu(6, 7, 3), 1, 2'b00, 2'b00, 0, 0, "t2_or_id");
      go(nop(),        1, 2'b00, 2'b01, 0, 0, "t2_or_ex_sel");

      // load-use: lw $8 ; add $9,$8,$8 (held in ID across the stall)
      rst();
      pre(lw(8, 1));
      go(alu(9, 8, 8), 1, 2'b00, 2'b00, 1, 0, "t3_loaduse_stall");
      go(alu(9, 8, 8), 1, 2'b00, 2'b00, 0, 1, "t3_reeval_nostall");
      go(nop(),        1, 2'b01, 2'b01, 0, 1, "t3_add_ex_sel");

      // $0 writers never forward; then newest producer wins
      rst();
      pre(alu(0, 1, 2));
      go(alu(0, 1, 2), 1, 2'b00, 2'b00, 0, 0, "t4_w0_w0");
      go(alu(5, 0, 0), 1, 2'b00, 2'b00, 0, 0, "t4_r0_nostall");
      go(nop(),        1, 2'b00, 2'b00, 0, 0, "t4_r0_ex_sel");
      pre(alu(2, 1, 1));
      pre(alu(2, 1, 1));
      go(alu(7, 2, 1), 1, 2'b00, 2'b00, 0, 0, "t4_r2_id");
      go(nop(),        1, 2'b10, 2'b00, 0, 0, "t4_newest_wins");

      // flush on the load-use cycle; then reset during a stall
      rst();
      pre(lw(8, 1));
      step(alu(9, 8, 8), 1, 0, 0, 1, 1, 2'b00, 2'b00, 0, 0, "t5_flush_kills_stall");
      go(nop(), 1, 2'b00, 2'b00, 0, 0, "t5_bubble_no_count");
      pre(lw(8, 1));
      step(alu(9, 8, 8), 0, 0, 1, 1, 1, 2'b00, 2'b00, 1, 0, "t5_stall_with_reset");
      go(alu(9, 8, 8), 1, 2'b00, 2'b00, 0, 0, "t5_after_reset");
      go(nop(),        1, 2'b00, 2'b00, 0, 0, "t5_shadows_discarded");

      // no forwarding: 2 stall cycles, hold freezes mid-stall, then wrap
      rst();
      pre(alu(3, 1, 2));
      go(alu(8, 3, 4), 0, 2'b00, 2'b00, 1, 0, "t6_stall_ex");
      step(alu(8, 3, 4), 0, 1, 0, 1, 0, 2'b00, 2'b00, 1, 1, "t6_hold1");
      step(alu(8, 3, 4), 0, 1, 0, 1, 0, 2'b00, 2'b00, 1, 1, "t6_hold2");
      step(alu(8, 3, 4), 0, 1, 0, 1, 0, 2'b00, 2'b00, 1, 1, "t6_hold3");
      go(alu(8, 3, 4), 0, 2'b00, 2'b00, 1, 1, "t6_stall_mem");
      go(alu(8, 3, 4), 0, 2'b00, 2'b00, 0, 2, "t6_release");
      go(nop(),        0, 2'b00, 2'b00, 0, 2, "t6_ex_sel_rf");
      go(alu(3, 1, 2), 0, 2'b00, 2'b00, 0, 2, "t6_indep");
      go(alu(8, 3, 4), 0, 2'b00, 2'b00, 1, 2, "t6_stall_again");
      go(alu(8, 3, 4), 0, 2'b00, 2'b00, 1, 3, "t6_cnt_max");
      go(alu(8, 3, 4), 0, 2'b00, 2'b00, 0, 0, "t6_cnt_wrap");

      repeat (3) @(posedge clk);
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
